// File: rtl/pwm_capture.sv
// PWM period/duty capture: synchronizes an asynchronous PWM input, measures
// period and high time in prescaled ticks, and flags counter saturation.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             pwm_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] prescaler_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] duty_o,
  output logic             valid_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Saturating increment: the counter parks at all-ones so a missing edge
  // shows up as a timeout instead of a silently wrapped measurement.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (&val) ? val : val + CNT_ONE;
  endfunction

  function automatic logic is_sat(input logic [CNT_W-1:0] val);
    return &val;
  endfunction

  state_t              state_q;
  state_t              state_d;
  logic [SYNC_STAGES-1:0] pwm_sync_p0;
  logic                pwm_sync_p1;
  logic                rise;
  logic                fall;
  logic [CNT_W-1:0]    presc_cnt;
  logic [CNT_W-1:0]    presc_lat;
  logic                tick;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    high_q;
  logic                counting;
  logic                timeout_hit;
  logic                capture_hi;
  logic                capture_meas;

  // Stage p0: metastability chain; stage p1: delayed copy for edge detection
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pwm_sync_p0 <= '0;
      pwm_sync_p1 <= 1'b0;
    end else begin
      pwm_sync_p0 <= {pwm_sync_p0[SYNC_STAGES-2:0], pwm_i};
      pwm_sync_p1 <= pwm_sync_p0[SYNC_STAGES-1];
    end
  end

  assign rise = pwm_sync_p0[SYNC_STAGES-1] & ~pwm_sync_p1;
  assign fall = ~pwm_sync_p0[SYNC_STAGES-1] & pwm_sync_p1;

  // Prescaler restarts on every rise so each period is timed against the
  // divider value captured at its own start.
  assign tick = (presc_cnt == presc_lat);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      presc_cnt <= '0;
      presc_lat <= '0;
    end else if (rise) begin
      presc_cnt <= '0;
      presc_lat <= prescaler_i;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + CNT_ONE;
    end
  end

  assign counting    = (state_q == HIGH) || (state_q == LOW);
  assign timeout_hit = enable_i && counting && tick && is_sat(count_q) && !rise && !fall;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      count_q <= '0;
    end else if (rise) begin
      count_q <= CNT_ONE;
    end else if (counting && tick) begin
      count_q <= sat_inc(count_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:      state_d = WAIT_RISE;
        WAIT_RISE: if (rise) state_d = HIGH;
        HIGH: begin
          if (fall)             state_d = LOW;
          else if (timeout_hit) state_d = WAIT_RISE;
        end
        LOW: begin
          if (rise)             state_d = HIGH;
          else if (timeout_hit) state_d = WAIT_RISE;
        end
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    capture_hi   = 1'b0;
    capture_meas = 1'b0;
    if (enable_i) begin
      capture_hi   = (state_q == HIGH) && fall;
      capture_meas = (state_q == LOW) && rise;
    end
  end

  // Stage p2: measurement registers; outputs only move on a completed period
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      high_q    <= '0;
      period_o  <= '0;
      duty_o    <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      if (capture_hi) begin
        high_q <= count_q;
      end
      if (capture_meas) begin
        period_o <= count_q;
        duty_o   <= high_q;
      end
      valid_o   <= capture_meas;
      timeout_o <= timeout_hit;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed and randomized bench for pwm_capture; expected measurements come
// from a closed-form tick-count model of the waveform segments.
module tb_pwm_capture;

  typedef struct {
    int per;
    int duty;
    int cyc;
  } meas_t;

  logic        clk;
  logic        rstn;
  logic        pwm;
  logic        en;
  logic [15:0] presc;
  logic [15:0] period;
  logic [15:0] duty;
  logic        valid;
  logic        timeout;

  logic        pwm8;
  logic        en8;
  logic [7:0]  presc8;
  logic [7:0]  period8;
  logic [7:0]  duty8;
  logic        valid8;
  logic        timeout8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  meas_t vq[$];
  meas_t vq8[$];
  int tq[$];
  int tq8[$];

  pwm_capture #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .pwm_i(pwm), .enable_i(en),
    .prescaler_i(presc), .period_o(period), .duty_o(duty),
    .valid_o(valid), .timeout_o(timeout)
  );

  pwm_capture #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
    .clk_i(clk), .rstn_i(rstn), .pwm_i(pwm8), .enable_i(en8),
    .prescaler_i(presc8), .period_o(period8), .duty_o(duty8),
    .valid_o(valid8), .timeout_o(timeout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid)    vq.push_back('{int'(period), int'(duty), cyc});
    if (valid8)   vq8.push_back('{int'(period8), int'(duty8), cyc});
    if (timeout)  tq.push_back(cyc);
    if (timeout8) tq8.push_back(cyc);
  end

  initial begin
    #800000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_period(input int h, input int l);
    pwm = 1'b1;
    step(h);
    pwm = 1'b0;
    step(l);
  endtask

  // Counter value reached 'clocks' cycles after a rise: 1 on the rise, then
  // one increment every (p+1) clocks.
  function automatic int exp_cnt(input int clocks, input int p);
    return 1 + (clocks - 1) / (p + 1);
  endfunction

  int p;
  int c0;
  int hs[3];
  int ls[3];

  initial begin
    rstn = 1'b0; pwm = 1'b0; en = 1'b0; presc = '0;
    pwm8 = 1'b0; en8 = 1'b0; presc8 = '0;
    step(3);
    check("rst_period", int'(period), 0);
    check("rst_duty", int'(duty), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_period8", int'(period8), 0);
    rstn = 1'b1;
    step(2);

    // Prescaler 0, 10-clock square wave with 3 clocks high
    presc = 16'd0; en = 1'b1;
    step(4);
    vq.delete();
    for (int i = 0; i < 4; i++) drive_period(3, 7);
    pwm = 1'b1;
    step(6);
    check("sq_count", vq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (vq.size() > i) begin
        check("sq_period", vq[i].per, 10);
        check("sq_duty", vq[i].duty, 3);
        if (i > 0) check("sq_interval", vq[i].cyc - vq[i-1].cyc, 10);
      end
    end
    en = 1'b0; pwm = 1'b0;
    step(4);

    // Prescaler 4, 50-clock period, 25 high
    presc = 16'd4; en = 1'b1;
    step(4);
    vq.delete();
    for (int i = 0; i < 3; i++) drive_period(25, 25);
    pwm = 1'b1;
    step(6);
    check("p4_count", vq.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (vq.size() > i) begin
        check("p4_period", vq[i].per, 10);
        check("p4_duty", vq[i].duty, 5);
      end
    end
    en = 1'b0; pwm = 1'b0;
    step(4);

    // Randomized waveforms and prescalers
    for (int t = 0; t < 6; t++) begin
      p = $urandom_range(3, 0);
      presc = 16'(p); en = 1'b1;
      step(4);
      vq.delete();
      for (int i = 0; i < 3; i++) begin
        hs[i] = $urandom_range(20, 2);
        ls[i] = $urandom_range(20, 2);
        drive_period(hs[i], ls[i]);
      end
      pwm = 1'b1;
      step(6);
      check("rnd_count", vq.size(), 3);
      for (int i = 0; i < 3; i++) begin
        if (vq.size() > i) begin
          check("rnd_period", vq[i].per, exp_cnt(hs[i] + ls[i], p));
          check("rnd_duty", vq[i].duty, exp_cnt(hs[i], p));
        end
      end
      en = 1'b0; pwm = 1'b0;
      step(4);
    end

    // Prescaler changed 2 -> 0 in the middle of a period
    presc = 16'd2; en = 1'b1;
    step(4);
    vq.delete();
    pwm = 1'b1;
    step(6);
    presc = 16'd0;
    step(6);
    pwm = 1'b0;
    step(12);
    drive_period(12, 12);
    pwm = 1'b1;
    step(6);
    check("pchg_count", vq.size(), 2);
    if (vq.size() > 1) begin
      check("pchg_period_old", vq[0].per, exp_cnt(24, 2));
      check("pchg_duty_old", vq[0].duty, exp_cnt(12, 2));
      check("pchg_period_new", vq[1].per, 24);
      check("pchg_duty_new", vq[1].duty, 12);
    end
    en = 1'b0; pwm = 1'b0;
    step(4);

    // Enable dropped during LOW, then restored
    presc = 16'd0; en = 1'b1;
    step(4);
    drive_period(4, 8);
    pwm = 1'b1;
    step(4);
    pwm = 1'b0;
    step(3);
    vq.delete();
    en = 1'b0;
    step(3);
    check("dis_period_held", int'(period), 12);
    check("dis_duty_held", int'(duty), 4);
    en = 1'b1;
    step(4);
    for (int i = 0; i < 2; i++) drive_period(5, 5);
    pwm = 1'b1;
    step(6);
    check("dis_count", vq.size(), 2);
    if (vq.size() > 0) begin
      check("dis_period", vq[0].per, 10);
      check("dis_duty", vq[0].duty, 5);
    end
    en = 1'b0; pwm = 1'b0;
    step(4);

    // Reset pulse while in HIGH
    en = 1'b1;
    step(4);
    drive_period(6, 6);
    pwm = 1'b1;
    step(5);
    check("prerst_period", int'(period), 12);
    vq.delete();
    rstn = 1'b0; pwm = 1'b0;
    step(1);
    rstn = 1'b1;
    check("midrst_period", int'(period), 0);
    check("midrst_duty", int'(duty), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_timeout", int'(timeout), 0);
    step(4);
    for (int i = 0; i < 2; i++) drive_period(7, 5);
    pwm = 1'b1;
    step(6);
    check("rst_restart_count", vq.size(), 2);
    if (vq.size() > 0) begin
      check("rst_restart_period", vq[0].per, 12);
      check("rst_restart_duty", vq[0].duty, 7);
    end
    en = 1'b0; pwm = 1'b0;
    step(4);
    check("main_no_timeout", tq.size(), 0);

    // 8-bit counter saturation with the input stuck high
    en8 = 1'b1;
    step(4);
    pwm8 = 1'b1; step(5);
    pwm8 = 1'b0; step(5);
    pwm8 = 1'b1;
    c0 = cyc;
    step(300);
    check("to_count", tq8.size(), 1);
    if (tq8.size() > 0) check("to_latency", tq8[0] - c0, 2 + 1 + 255);
    check("to_valid_count", vq8.size(), 1);
    check("to_period_held", int'(period8), 10);
    check("to_duty_held", int'(duty8), 5);
    pwm8 = 1'b0;
    step(5);
    vq8.delete();
    pwm8 = 1'b1; step(5);
    pwm8 = 1'b0; step(5);
    check("to_wait_rise", vq8.size(), 0);
    pwm8 = 1'b1;
    step(6);
    check("to_recover_count", vq8.size(), 1);
    if (vq8.size() > 0) begin
      check("to_recover_period", vq8[0].per, 10);
      check("to_recover_duty", vq8[0].duty, 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the period, duty and prescaler counters.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of flops in the pwm_i synchronizer (minimum 2).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port pwm_i  input  1  asynchronous PWM waveform from the IO pad input path.
REQ-006 SHALL have port enable_i  input  1  capture enable; 0 forces the IDLE state.
REQ-007 SHALL have port prescaler_i  input  CNT_W  tick divider; one tick every prescaler_i+1 clocks.
REQ-008 SHALL have port period_o  output  CNT_W  last measured period, in ticks.
REQ-009 SHALL have port duty_o  output  CNT_W  last measured high time, in ticks.
REQ-010 SHALL have port valid_o  output  1  one-cycle pulse when period_o/duty_o are updated.
REQ-011 SHALL have port timeout_o  output  1  one-cycle pulse when the counter saturates without an edge.

Function
REQ-012 SHALL pass pwm_i through SYNC_STAGES flops, then one further flop for edge detection; a rise/fall is "detected" in the cycle where the synchronized value differs from the delayed copy.
REQ-013 SHALL implement FSM states IDLE, WAIT_RISE, HIGH, LOW.
REQ-014 SHALL transition IDLE->WAIT_RISE when enable_i=1; any state->IDLE when enable_i=0, same cycle.
REQ-015 SHALL transition WAIT_RISE->HIGH on rise detect, with no measurement output.
REQ-016 SHALL transition HIGH->LOW on fall detect, latching the running count into an internal high register.
REQ-017 SHALL transition LOW->HIGH on rise detect, registering period_o=count, duty_o=high register and valid_o=1 in the next cycle.
REQ-018 SHALL, on every rise detect, load count=1, clear the prescaler counter and latch prescaler_i; prescaler changes take effect only from the next rise.
REQ-019 SHALL generate a tick when the prescaler counter equals the latched value, then wrap it to 0; count increments by 1 per tick in HIGH and LOW.
REQ-020 SHALL, with prescaler 0 and a waveform of P clocks period and H clocks high, report period_o=P and duty_o=H.
REQ-021 SHALL, when count equals 2^CNT_W-1 and a tick occurs without an edge in HIGH or LOW, pulse timeout_o, go to WAIT_RISE, and leave period_o/duty_o unchanged.
REQ-022 SHALL give an edge detect priority over a tick coinciding in the same cycle.
REQ-023 SHALL keep period_o/duty_o holding their last values in IDLE and WAIT_RISE; valid_o and timeout_o are 0 outside their pulse cycle.
REQ-024 SHALL treat a fall detect in WAIT_RISE or LOW, and a rise detect in HIGH, as impossible after synchronization; no special handling beyond the FSM.

Reset
REQ-025 SHALL, when rstn_i=0 at a clock edge, set state=IDLE, all counters, synchronizer flops, period_o, duty_o, valid_o and timeout_o to 0.
REQ-026 SHALL have a reset asserted mid-measurement discard the partial count; the first valid_o after release requires two further rising edges.

Verification
REQ-027 SHALL cover: prescaler 0, square wave P=10/H=3 clocks -> the first valid_o after the second detected rise, period_o=10, duty_o=3, then one valid_o every 10 clocks.
REQ-028 SHALL cover: prescaler 4, P=50/H=25 clocks -> period_o=10, duty_o=5 (tolerance +/-1 tick).
REQ-029 SHALL cover: CNT_W=8, prescaler 0, pwm_i held high after a rise -> timeout_o pulse 255 clocks after the rise; state WAIT_RISE; outputs unchanged.
REQ-030 SHALL cover: enable_i dropped mid-LOW, then re-raised -> no valid_o until two new rises; prior period_o/duty_o held.
REQ-031 SHALL cover: rstn_i low for 1 cycle mid-HIGH -> all outputs 0 next cycle; measurement restarts per REQ-026.
REQ-032 SHALL cover: prescaler_i changed 2->0 mid-period -> the current period is counted with prescaler 2; the new value is applied from the following rise.
